// File: rtl/div_unit_iter_if.sv
// rtl/div_unit_iter_if.sv - request/result handshake bundle for the iterative divider
interface div_unit_iter_if #(
  parameter int XLEN = 32
);
  logic            start_valid;
  logic            start_ready;
  logic [1:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            res_valid;
  logic            res_ready;
  logic [XLEN-1:0] result;
  logic            busy;

  modport master (
    output start_valid, op, a, b, res_ready,
    input  start_ready, res_valid, result, busy
  );

  modport slave (
    input  start_valid, op, a, b, res_ready,
    output start_ready, res_valid, result, busy
  );
endinterface

// File: rtl/div_unit_iter.sv
// rtl/div_unit_iter.sv - iterative restoring divider for DIV/DIVU/REM/REMU, one quotient bit per clock
module div_unit_iter #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_flush,
  div_unit_iter_if.slave   s_bus
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [XLEN-1:0]  r_rem;
  logic [XLEN-1:0]  r_quo;
  logic [XLEN-1:0]  r_div;
  logic [XLEN-1:0]  r_result;
  logic             r_sel_rem;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_special;

  logic            w_signed;
  logic            w_a_neg;
  logic            w_b_neg;
  logic [XLEN-1:0] w_a_mag;
  logic [XLEN-1:0] w_b_mag;
  logic            w_b_zero;
  logic            w_ovf;
  logic            w_special;
  logic [XLEN-1:0] w_special_res;
  logic            w_accept;
  logic            w_last;
  logic [XLEN:0]   w_shift;
  logic            w_fits;
  logic [XLEN-1:0] w_sub;
  logic [XLEN-1:0] w_rem_nxt;
  logic [XLEN-1:0] w_quo_nxt;
  logic [XLEN-1:0] w_q_final;
  logic [XLEN-1:0] w_r_final;
  logic [XLEN-1:0] w_final;

  assign w_signed = ~s_bus.op[0];
  assign w_a_neg  = w_signed & s_bus.a[XLEN-1];
  assign w_b_neg  = w_signed & s_bus.b[XLEN-1];
  assign w_a_mag  = w_a_neg ? -s_bus.a : s_bus.a;
  assign w_b_mag  = w_b_neg ? -s_bus.b : s_bus.b;
  assign w_b_zero = (s_bus.b == '0);
  assign w_ovf    = w_signed & (s_bus.a == {1'b1, {(XLEN-1){1'b0}}}) & (s_bus.b == '1);
  assign w_special = w_b_zero | w_ovf;
  assign w_special_res = w_b_zero ? (s_bus.op[1] ? s_bus.a : '1)
                                  : (s_bus.op[1] ? '0 : s_bus.a);

  assign w_accept = (r_state == S_IDLE) & s_bus.start_valid & ~i_flush;
  assign w_last   = (r_cnt == CNT_W'(XLEN-1));

  // The (XLEN+1)-bit trial: the compare is the borrow, the low XLEN bits are exact when it fits.
  assign w_shift   = {r_rem, r_quo[XLEN-1]};
  assign w_fits    = (w_shift >= {1'b0, r_div});
  assign w_sub     = w_shift[XLEN-1:0] - r_div;
  assign w_rem_nxt = w_fits ? w_sub : w_shift[XLEN-1:0];
  assign w_quo_nxt = {r_quo[XLEN-2:0], w_fits};
  assign w_q_final = r_neg_q ? -w_quo_nxt : w_quo_nxt;
  assign w_r_final = r_neg_r ? -w_rem_nxt : w_rem_nxt;
  assign w_final   = r_sel_rem ? w_r_final : w_q_final;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (s_bus.start_valid)        w_state_nxt = S_CALC;
      S_CALC:  if (r_special || w_last)      w_state_nxt = S_DONE;
      S_DONE:  if (s_bus.res_ready)          w_state_nxt = S_IDLE;
      default:                               w_state_nxt = S_IDLE;
    endcase
    if (i_flush) w_state_nxt = S_IDLE;
  end

  // Special cases still pass through CALC for one clock so their result lands one edge after accept.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt     <= '0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_div     <= '0;
      r_result  <= '0;
      r_sel_rem <= 1'b0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_special <= 1'b0;
    end else if (i_flush) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_cnt     <= '0;
      r_rem     <= '0;
      r_quo     <= w_special ? w_special_res : w_a_mag;
      r_div     <= w_b_mag;
      r_sel_rem <= s_bus.op[1];
      r_neg_q   <= w_a_neg ^ w_b_neg;
      r_neg_r   <= w_a_neg;
      r_special <= w_special;
    end else if (r_state == S_CALC) begin
      if (r_special) begin
        r_result <= r_quo;
      end else begin
        r_rem <= w_rem_nxt;
        r_quo <= w_quo_nxt;
        r_cnt <= w_last ? '0 : r_cnt + 1'b1;
        if (w_last) r_result <= w_final;
      end
    end
  end

  assign s_bus.start_ready = (r_state == S_IDLE);
  assign s_bus.res_valid   = (r_state == S_DONE);
  assign s_bus.busy        = (r_state != S_IDLE);
  assign s_bus.result      = r_result;

endmodule

// File: tb/tb_div_unit_iter.sv
// tb/tb_div_unit_iter.sv - randomized self-checking bench for div_unit_iter against an arithmetic model
module tb_div_unit_iter;

  logic clk;
  logic rst_n;
  logic flush;
  int   n_pass;
  int   n_total;
  logic [31:0] exp_q[$];

  div_unit_iter_if #(.XLEN(32)) bus ();

  div_unit_iter #(.XLEN(32), .CNT_W(6)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_flush (flush),
    .s_bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0]) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return op[1] ? r[31:0] : q[31:0];
  endfunction

  function automatic bit is_special(input logic [1:0] op, input logic [31:0] a,
                                    input logic [31:0] b);
    return (b == 32'd0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(5))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(20));
      default: return $urandom;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", name, act, exp);
  endtask

  // Continuous scoreboard: every cycle a result is presented it must match the oldest accepted op.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.res_valid) begin
        if (exp_q.size() == 0) begin
          check_bit("stale_res_valid", bus.res_valid, 1'b0);
        end else begin
          check("scoreboard_result", bus.result, exp_q[0]);
          if (bus.res_ready) void'(exp_q.pop_front());
        end
      end
      if (flush) exp_q.delete();
    end
  end

  task automatic start_only(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    check_bit("start_ready_before_send", bus.start_ready, 1'b1);
    bus.op = op;
    bus.a  = a;
    bus.b  = b;
    bus.start_valid = 1'b1;
    @(posedge clk);
    exp_q.push_back(ref_div(op, a, b));
    #1;
    bus.start_valid = 1'b0;
    bus.op = 2'($urandom_range(3));
    bus.a  = $urandom;
    bus.b  = $urandom;
  endtask

  task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                      output logic [31:0] got);
    int lat;
    int exp_lat;
    exp_lat = is_special(op, a, b) ? 1 : 32;
    start_only(op, a, b);
    lat = 0;
    while (1) begin
      @(posedge clk);
      #1;
      lat++;
      if (bus.res_valid || lat > 40) break;
    end
    check("latency", 32'(lat), 32'(exp_lat));
    got = bus.result;
  endtask

  task automatic recv(input int stall);
    logic [31:0] held;
    held = bus.result;
    bus.res_ready = 1'b0;
    for (int i = 0; i < stall; i++) begin
      bus.start_valid = 1'b1;
      @(posedge clk);
      #1;
      check_bit("hold_res_valid", bus.res_valid, 1'b1);
      check("hold_result", bus.result, held);
      check_bit("hold_start_ready", bus.start_ready, 1'b0);
    end
    bus.start_valid = 1'b0;
    bus.res_ready   = 1'b1;
    @(posedge clk);
    #1;
    bus.res_ready = 1'b0;
    check_bit("handoff_res_valid", bus.res_valid, 1'b0);
    check_bit("handoff_start_ready", bus.start_ready, 1'b1);
  endtask

  task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] lit);
    logic [31:0] got;
    check({"model_", name}, ref_div(op, a, b), lit);
    send(op, a, b, got);
    check(name, got, lit);
    recv(0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] got;
    logic [1:0]  rop;
    logic [31:0] ra, rb;
    n_pass = 0;
    n_total = 0;
    rst_n = 1'b0;
    flush = 1'b0;
    bus.start_valid = 1'b0;
    bus.res_ready   = 1'b0;
    bus.op = 2'd0;
    bus.a  = 32'd0;
    bus.b  = 32'd0;
    #1;
    check_bit("reset_res_valid", bus.res_valid, 1'b0);
    check_bit("reset_busy", bus.busy, 1'b0);
    check("reset_result", bus.result, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    check_bit("post_reset_start_ready", bus.start_ready, 1'b1);

    run_op("divu_100_7", 2'b01, 32'd100, 32'd7, 32'd14);
    run_op("remu_100_7", 2'b11, 32'd100, 32'd7, 32'd2);
    run_op("div_m7_2", 2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    run_op("rem_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
    run_op("rem_7_m2", 2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1);
    run_op("divu_by0", 2'b01, 32'h1234, 32'd0, 32'hFFFF_FFFF);
    run_op("remu_by0", 2'b11, 32'h1234, 32'd0, 32'h1234);
    run_op("div_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    run_op("rem_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);

    send(2'b01, 32'd1000, 32'd33, got);
    check("bp_result", got, 32'd30);
    recv(5);

    start_only(2'b01, 32'd1000, 32'd3);
    repeat (10) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    check_bit("flush_busy", bus.busy, 1'b0);
    check_bit("flush_start_ready", bus.start_ready, 1'b1);
    check_bit("flush_res_valid", bus.res_valid, 1'b0);
    repeat (35) @(posedge clk);
    #1;
    check_bit("flush_no_result", bus.res_valid, 1'b0);
    run_op("divu_9_3", 2'b01, 32'd9, 32'd3, 32'd3);

    start_only(2'b01, 32'd12345, 32'd7);
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_bit("midcalc_reset_busy", bus.busy, 1'b0);
    check_bit("midcalc_reset_res_valid", bus.res_valid, 1'b0);
    check("midcalc_reset_result", bus.result, 32'd0);
    exp_q.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check_bit("after_reset_no_result", bus.res_valid, 1'b0);
    run_op("divu_max_1", 2'b01, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF);
    run_op("divu_5_10", 2'b01, 32'd5, 32'd10, 32'd0);

    for (int i = 0; i < 150; i++) begin
      rop = 2'($urandom_range(3));
      ra  = pick();
      rb  = pick();
      send(rop, ra, rb, got);
      check("random_result", got, ref_div(rop, ra, rb));
      recv(int'($urandom_range(2)));
    end

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
